alu_share_arbiter: RTL and testbench

Shares the single combinational ALU (6-bit ALUC opcode, 32-bit a/b, r plus zero/carry/negative/overflow flags) between two requesters: port 0 is the pipeline EX stage and port 1 is the multi-cycle/CP0 helper. The block does valid/ready arbitration, registers the operands into the ALU, and captures the result and flags one cycle later. It returns the result on a single tagged response channel with backpressure.

---
 rtl/alu_share_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters; define ALU_SHARE_ARBITER_PERF_EN for perf counters
module alu_share_arbiter #(
  parameter int TAG_W = 4,
  parameter logic [5:0] MAX_ALUC = 6'b110101
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_aluc,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_aluc,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [5:0]       alu_aluc,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_r,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_port,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_r,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err
`ifdef ALU_SHARE_ARBITER_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [31:0]      perf_grant0,
  output logic [31:0]      perf_grant1,
  output logic [31:0]      perf_stall
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic r_last_grant;
  logic w_gnt0, w_gnt1, w_acc, w_port, w_illegal;
  logic [5:0] w_aluc;
  logic [31:0] w_a, w_b;
  logic [TAG_W-1:0] w_tag;
  assign w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
  assign w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
  assign req0_ready = rst_n && r_state == IDLE && w_gnt0;
  assign req1_ready = rst_n && r_state == IDLE && w_gnt1;
  assign w_acc = req0_ready || req1_ready;
  assign w_port = req1_ready;
  assign w_aluc = w_port ? req1_aluc : req0_aluc;
  assign w_a = w_port ? req1_a : req0_a;
  assign w_b = w_port ? req1_b : req0_b;
  assign w_tag = w_port ? req1_tag : req0_tag;
  assign w_illegal = w_aluc > MAX_ALUC;
  assign rsp_valid = r_state == RESP;
  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next state: illegal opcodes skip the ALU cycle and answer directly
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_acc ? (w_illegal ? RESP : EXEC) : IDLE;
      EXEC: w_next = RESP;
      RESP: w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // Operand issue on accept, result capture in EXEC; alu_* hold between ops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      alu_aluc <= '0;
      alu_a <= '0;
      alu_b <= '0;
      rsp_port <= 1'b0;
      rsp_tag <= '0;
      rsp_r <= '0;
      rsp_flags <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (w_acc) begin
        r_last_grant <= w_port;
        rsp_port <= w_port;
        rsp_tag <= w_tag;
        if (w_illegal) begin
          rsp_r <= '0;
          rsp_flags <= '0;
          rsp_err <= 1'b1;
        end else begin
          alu_aluc <= w_aluc;
          alu_a <= w_a;
          alu_b <= w_b;
        end
      end
      if (r_state == EXEC) begin
        rsp_r <= alu_r;
        rsp_flags <= {alu_overflow, alu_negative, alu_carry, alu_zero};
        rsp_err <= 1'b0;
      end
    end
  end
`ifdef ALU_SHARE_ARBITER_PERF_EN
  // Accept counts per port and backpressure stall cycles; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall <= '0;
    end else begin
      if (req0_ready) perf_grant0 <= perf_grant0 + 32'd1;
      if (req1_ready) perf_grant1 <= perf_grant1 + 32'd1;
      if (rsp_valid && !rsp_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of the shared-ALU arbiter against a transaction model
module tb_alu_share_arbiter;
  typedef struct packed {
    logic port;
    logic [3:0] tag;
    logic [31:0] r;
    logic [3:0] flags;
    logic err;
  } rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [5:0] req0_aluc = '0, req1_aluc = '0, alu_aluc;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0, alu_a, alu_b, alu_r;
  logic [3:0] req0_tag = '0, req1_tag = '0, rsp_tag, rsp_flags;
  logic alu_zero, alu_carry, alu_negative, alu_overflow;
  logic rsp_valid, rsp_port, rsp_err;
  logic rsp_ready = 1'b0;
  logic [31:0] rsp_r;
`ifdef ALU_SHARE_ARBITER_PERF_EN
  logic perf_clr = 1'b0;
  logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  // Stand-in ALU: {overflow, negative, carry, zero, r}
  function automatic logic [35:0] alu_fn(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic cy, ov;
    cy = 1'b0;
    ov = 1'b0;
    if (c == 6'd1) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[31:0];
      cy = s[32];
      ov = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (c == 6'd2) begin
      r = a - b;
      cy = a < b;
      ov = (a[31] != b[31]) && (r[31] != a[31]);
    end else if (c == 6'd5) r = a | b;
    else r = a ^ b;
    return {ov, r[31], cy, r == 32'd0, r};
  endfunction
  function automatic rsp_t expect_rsp(input logic p, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    logic [35:0] v;
    v = alu_fn(c, a, b);
    if (c > 6'h35) return {p, t, 32'd0, 4'd0, 1'b1};
    return {p, t, v[31:0], v[35:32], 1'b0};
  endfunction
  assign {alu_overflow, alu_negative, alu_carry, alu_zero, alu_r} = alu_fn(alu_aluc, alu_a, alu_b);
  alu_share_arbiter #(.TAG_W(4), .MAX_ALUC(6'b110101)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluc(req0_aluc), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluc(req1_aluc), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .alu_aluc(alu_aluc), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port), .rsp_tag(rsp_tag),
    .rsp_r(rsp_r), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
`ifdef ALU_SHARE_ARBITER_PERF_EN
    , .perf_clr(perf_clr), .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );
  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask
  task automatic set_req(input int p, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    if (p == 0) begin
      req0_valid = 1'b1; req0_aluc = c; req0_a = a; req0_b = b; req0_tag = t;
    end else begin
      req1_valid = 1'b1; req1_aluc = c; req1_a = a; req1_b = b; req1_tag = t;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_ready(output int p);
    p = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req0_ready) begin p = 0; return; end
      if (req1_ready) begin p = 1; return; end
      @(negedge clk);
    end
  endtask
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask
  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    n_chk++;
    if ({rsp_valid, rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err} !== 43'd0) begin n_fail++; $display("FAIL reset_rsp: got v=%b p=%b t=%h r=%h f=%h e=%b expected all 0", rsp_valid, rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err); end
    n_chk++;
    if ({alu_aluc, alu_a, alu_b} !== 70'd0) begin n_fail++; $display("FAIL reset_alu: got %h %h %h expected 0", alu_aluc, alu_a, alu_b); end
`ifdef ALU_SHARE_ARBITER_PERF_EN
    n_chk++;
    if ({perf_grant0, perf_grant1, perf_stall} !== 96'd0) begin n_fail++; $display("FAIL reset_perf: got %h %h %h expected 0", perf_grant0, perf_grant1, perf_stall); end
`endif
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_addu();
    int p;
    set_req(0, 6'd1, 32'hFFFFFFFF, 32'd1, 4'd7);
    wait_ready(p);
    n_chk++;
    if (p !== 0) begin n_fail++; $display("FAIL addu_grant: got %0d expected 0", p); end
    @(negedge clk);
    req0_valid = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL addu_early_valid: got %b expected 0", rsp_valid); end
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err} !== {1'b1, 1'b0, 4'd7, 32'd0, 4'b0011, 1'b0})
      begin n_fail++; $display("FAIL addu_rsp: got v=%b p=%b t=%h r=%h f=%b e=%b expected v=1 p=0 t=7 r=0 f=0011 e=0", rsp_valid, rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err); end
    consume();
    n_chk++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL addu_drop: got %b expected 0", rsp_valid); end
  endtask
  task automatic test_tie();
    int p;
    bit ok;
    do_reset();
    set_req(0, 6'd5, 32'h0F0F0000, 32'h000000F0, 4'd3);
    set_req(1, 6'd5, 32'h12340000, 32'h00005678, 4'd5);
    wait_ready(p);
    n_chk++;
    if (p !== 0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL tie1_grant: got port %0d r1=%b expected port 0 only", p, req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(ok);
    n_chk++;
    if (!ok || {rsp_port, rsp_tag, rsp_r} !== {1'b0, 4'd3, 32'h0F0F00F0}) begin n_fail++; $display("FAIL tie1_rsp: got ok=%b p=%b t=%h r=%h expected p=0 t=3 r=0f0f00f0", ok, rsp_port, rsp_tag, rsp_r); end
    consume();
    wait_ready(p);
    n_chk++;
    if (p !== 1) begin n_fail++; $display("FAIL tie2_grant: got %0d expected 1", p); end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(ok);
    n_chk++;
    if (!ok || {rsp_port, rsp_tag, rsp_r} !== {1'b1, 4'd5, 32'h12345678}) begin n_fail++; $display("FAIL tie2_rsp: got ok=%b p=%b t=%h r=%h expected p=1 t=5 r=12345678", ok, rsp_port, rsp_tag, rsp_r); end
    consume();
    set_req(0, 6'd5, 32'd1, 32'd2, 4'd1);
    set_req(1, 6'd5, 32'd3, 32'd4, 4'd2);
    wait_ready(p);
    n_chk++;
    if (p !== 0) begin n_fail++; $display("FAIL tie3_grant: got %0d expected 0", p); end
    @(negedge clk);
    idle_inputs();
    wait_rsp(ok);
    consume();
  endtask
  task automatic test_sub();
    int p;
    bit ok;
    set_req(1, 6'd2, 32'h80000000, 32'd1, 4'hA);
    wait_ready(p);
    n_chk++;
    if (p !== 1) begin n_fail++; $display("FAIL sub_grant: got %0d expected 1", p); end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(ok);
    n_chk++;
    if (!ok || {rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err} !== {1'b1, 4'hA, 32'h7FFFFFFF, 4'b1000, 1'b0})
      begin n_fail++; $display("FAIL sub_rsp: got ok=%b p=%b t=%h r=%h f=%b e=%b expected p=1 t=a r=7fffffff f=1000 e=0", ok, rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err); end
    consume();
  endtask
  task automatic test_illegal();
    int p;
    bit ok;
    set_req(0, 6'h3F, 32'hDEADBEEF, 32'hCAFEF00D, 4'd9);
    wait_ready(p);
    @(negedge clk);
    req0_valid = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err} !== {1'b1, 1'b0, 4'd9, 32'd0, 4'd0, 1'b1})
      begin n_fail++; $display("FAIL illegal_rsp: got v=%b p=%b t=%h r=%h f=%b e=%b expected v=1 p=0 t=9 r=0 f=0 e=1", rsp_valid, rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err); end
    n_chk++;
    if ({alu_aluc, alu_a, alu_b} !== {6'd2, 32'h80000000, 32'd1}) begin n_fail++; $display("FAIL illegal_alu_hold: got %h %h %h expected 02 80000000 00000001", alu_aluc, alu_a, alu_b); end
    consume();
    set_req(0, 6'h36, 32'd1, 32'd1, 4'd4);
    wait_ready(p);
    @(negedge clk);
    req0_valid = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_err} !== 2'b11) begin n_fail++; $display("FAIL illegal_36: got v=%b e=%b expected 1 1", rsp_valid, rsp_err); end
    consume();
    set_req(0, 6'h35, 32'h0000FF00, 32'h00FF0000, 4'd6);
    wait_ready(p);
    @(negedge clk);
    req0_valid = 1'b0;
    n_chk++;
    if ({rsp_valid, alu_aluc} !== {1'b0, 6'h35}) begin n_fail++; $display("FAIL legal_35_issue: got v=%b aluc=%h expected 0 35", rsp_valid, alu_aluc); end
    wait_rsp(ok);
    n_chk++;
    if (!ok || {rsp_err, rsp_r} !== {1'b0, 32'h00FFFF00}) begin n_fail++; $display("FAIL legal_35_rsp: got ok=%b e=%b r=%h expected e=0 r=00ffff00", ok, rsp_err, rsp_r); end
    consume();
  endtask
  task automatic test_stall();
    int p;
    bit ok;
`ifdef ALU_SHARE_ARBITER_PERF_EN
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
`endif
    set_req(1, 6'd1, 32'd100, 32'd200, 4'd2);
    wait_ready(p);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(ok);
    set_req(0, 6'd1, 32'd1, 32'd1, 4'd1);
    set_req(1, 6'd1, 32'd1, 32'd1, 4'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++;
      if ({rsp_valid, rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err, req0_ready, req1_ready} !== {1'b1, 1'b1, 4'd2, 32'd300, 4'd0, 1'b0, 2'b00})
        begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b p=%b t=%h r=%h f=%b e=%b rdy=%b%b expected v=1 p=1 t=2 r=12c f=0 e=0 rdy=00", i, rsp_valid, rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err, req0_ready, req1_ready); end
      @(negedge clk);
    end
`ifdef ALU_SHARE_ARBITER_PERF_EN
    n_chk++;
    if ({perf_stall, perf_grant0, perf_grant1} !== {32'd5, 32'd0, 32'd1}) begin n_fail++; $display("FAIL perf: got stall=%0d g0=%0d g1=%0d expected 5 0 1", perf_stall, perf_grant0, perf_grant1); end
`endif
    idle_inputs();
    consume();
  endtask
  task automatic test_reset_mid();
    int p;
    bit ok;
    set_req(0, 6'd1, 32'd5, 32'd6, 4'd1);
    wait_ready(p);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid[%0d]: got %b expected 0", i, rsp_valid); end
      @(negedge clk);
    end
    n_chk++;
    if ({rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err, alu_aluc, alu_a, alu_b} !== 112'd0)
      begin n_fail++; $display("FAIL rstmid_values: got p=%b t=%h r=%h f=%b e=%b alu=%h %h %h expected 0", rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err, alu_aluc, alu_a, alu_b); end
    set_req(0, 6'd5, 32'd1, 32'd2, 4'd1);
    set_req(1, 6'd5, 32'd3, 32'd4, 4'd2);
    wait_ready(p);
    n_chk++;
    if (p !== 0) begin n_fail++; $display("FAIL rstmid_tie: got %0d expected 0", p); end
    @(negedge clk);
    idle_inputs();
    wait_rsp(ok);
    consume();
  endtask
  task automatic test_random();
    rsp_t q[$];
    rsp_t got;
    int prev, issued, p;
    bit acc0, acc1;
    do_reset();
    prev = 1;
    issued = 0;
    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int cyc = 0; cyc < 5000 && (issued < 150 || q.size() != 0); cyc++) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (!req0_valid && issued < 150 && $urandom_range(0, 2) == 0)
        set_req(0, 6'($urandom_range(0, 63)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (!req1_valid && issued < 150 && $urandom_range(0, 2) == 0)
        set_req(1, 6'($urandom_range(0, 63)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (rsp_valid && rsp_ready) begin
        got = {rsp_port, rsp_tag, rsp_r, rsp_flags, rsp_err};
        n_chk++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rand_unexpected_rsp: got %h expected none", got); end
        else begin
          if (got !== q[0]) begin n_fail++; $display("FAIL rand_rsp: got %h expected %h", got, q[0]); end
          void'(q.pop_front());
        end
      end
      if (req0_ready && req1_ready) begin n_chk++; n_fail++; $display("FAIL rand_both_ready: got 11 expected at most one"); end
      if ((req0_ready || req1_ready) && rsp_valid) begin n_chk++; n_fail++; $display("FAIL rand_ready_in_resp: got ready=1 expected 0"); end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        p = req0_ready ? 0 : 1;
        if (req0_valid && req1_valid) begin
          n_chk++;
          if (p == prev) begin n_fail++; $display("FAIL rand_rr: got port %0d expected %0d", p, 1 - prev); end
        end
        prev = p;
        issued++;
        if (p == 0) begin q.push_back(expect_rsp(1'b0, req0_aluc, req0_a, req0_b, req0_tag)); acc0 = 1'b1; end
        else begin q.push_back(expect_rsp(1'b1, req1_aluc, req1_a, req1_b, req1_tag)); acc1 = 1'b1; end
      end
      @(negedge clk);
    end
    idle_inputs();
    n_chk++;
    if (issued < 150 || q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got issued=%0d pending=%0d expected 150 and 0", issued, q.size()); end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    test_reset();
    test_addu();
    test_tie();
    test_sub();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
